// File: rtl/fifo_byte_unpacker.sv
// Drains words from a show-ahead FIFO and re-emits each one as a stream of
// bytes over a valid/ready interface, reloading without a bubble when possible.
module fifo_byte_unpacker #(
    parameter int FWIDTH    = 32,
    parameter int BWIDTH    = 8,
    parameter int MSB_FIRST = 1,
    parameter int WCWIDTH   = 16
) (
    input  logic               Clk,
    input  logic               RstN,
    input  logic               EnN,
    input  logic               ClrN,
    input  logic [FWIDTH-1:0]  F_Data,
    input  logic               F_EmptyN,
    output logic               FOutN,
    output logic [BWIDTH-1:0]  Byte_Data,
    output logic               Byte_Valid,
    input  logic               Byte_Ready,
    output logic               Byte_Last,
    output logic               Busy,
    output logic [WCWIDTH-1:0] Word_Cnt
);

    localparam int NB  = FWIDTH / BWIDTH;
    localparam int BIW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [FWIDTH-1:0]    hold_q, hold_d;
    logic [BIW-1:0]       bidx_q, bidx_d;
    logic [WCWIDTH-1:0]   word_cnt_q, word_cnt_d;

    logic accept;
    logic last;
    logic reload_ok;
    logic rd;

    function automatic logic [BWIDTH-1:0] sel_byte(input logic [FWIDTH-1:0] w,
                                                   input logic [BIW-1:0]    idx);
        int pos;
        pos = (MSB_FIRST != 0) ? (NB - 1 - int'(idx)) : int'(idx);
        return w[pos*BWIDTH +: BWIDTH];
    endfunction

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            bidx_q     <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            bidx_q     <= bidx_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // The read strobe is gated by RstN so no word is pulled while reset is held.
    always_comb begin
        accept    = (state_q == SHIFT) & Byte_Ready;
        last      = (bidx_q == BIW'(NB - 1));
        reload_ok = ClrN & ~EnN & F_EmptyN;
        rd        = RstN & reload_ok & ((state_q == IDLE) | (accept & last));
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        bidx_d     = bidx_q;
        word_cnt_d = word_cnt_q;
        if (!ClrN) begin
            state_d    = IDLE;
            hold_d     = '0;
            bidx_d     = '0;
            word_cnt_d = '0;
        end else if (rd) begin
            state_d    = SHIFT;
            hold_d     = F_Data;
            bidx_d     = '0;
            word_cnt_d = word_cnt_q + WCWIDTH'(1);
        end else if (accept) begin
            if (last) begin
                state_d = IDLE;
            end else begin
                bidx_d = bidx_q + BIW'(1);
            end
        end
    end

    always_comb begin
        Byte_Valid = (state_q == SHIFT);
        Busy       = (state_q == SHIFT);
        Byte_Last  = (state_q == SHIFT) & last;
        Byte_Data  = (state_q == SHIFT) ? sel_byte(hold_q, bidx_q) : '0;
        FOutN      = ~rd;
        Word_Cnt   = word_cnt_q;
    end

endmodule

// File: tb/tb_fifo_byte_unpacker.sv
// Scoreboard bench for fifo_byte_unpacker: an MSB-first and an LSB-first
// instance share one FIFO model and are checked against a cycle model each step.
module tb_fifo_byte_unpacker;

    localparam int WCW = 3;

    logic            Clk = 1'b0;
    logic            RstN, EnN, ClrN, F_EmptyN, Byte_Ready;
    logic [31:0]     F_Data;
    logic            fout0, fout1, bv0, bv1, bl0, bl1, busy0, busy1;
    logic [7:0]      bd0, bd1;
    logic [WCW-1:0]  wc0, wc1;

    fifo_byte_unpacker #(.FWIDTH(32), .BWIDTH(8), .MSB_FIRST(1), .WCWIDTH(WCW)) u_msb (
        .Clk(Clk), .RstN(RstN), .EnN(EnN), .ClrN(ClrN), .F_Data(F_Data), .F_EmptyN(F_EmptyN),
        .FOutN(fout0), .Byte_Data(bd0), .Byte_Valid(bv0), .Byte_Ready(Byte_Ready),
        .Byte_Last(bl0), .Busy(busy0), .Word_Cnt(wc0));

    fifo_byte_unpacker #(.FWIDTH(32), .BWIDTH(8), .MSB_FIRST(0), .WCWIDTH(WCW)) u_lsb (
        .Clk(Clk), .RstN(RstN), .EnN(EnN), .ClrN(ClrN), .F_Data(F_Data), .F_EmptyN(F_EmptyN),
        .FOutN(fout1), .Byte_Data(bd1), .Byte_Valid(bv1), .Byte_Ready(Byte_Ready),
        .Byte_Last(bl1), .Busy(busy1), .Word_Cnt(wc1));

    always #5 Clk = ~Clk;

    logic [31:0]    fifo_q[$];
    logic [7:0]     sb_msb[$];
    logic [7:0]     sb_lsb[$];
    logic           m_busy = 1'b0;
    int             m_bidx = 0;
    logic [WCW-1:0] m_cnt  = '0;
    int             vectors = 0;
    int             miscompares = 0;
    int             dut_reads = 0;
    int             dut_valids = 0;

    // One clock cycle: present FIFO head, check outputs, clock, advance the model.
    task automatic step();
        logic acc, rd;
        logic [31:0] w;
        F_EmptyN = (fifo_q.size() != 0);
        F_Data   = F_EmptyN ? fifo_q[0] : 32'hDEAD_BEEF;
        #1;
        acc = m_busy & Byte_Ready;
        rd  = RstN & ClrN & ~EnN & F_EmptyN & (!m_busy | (acc & (m_bidx == 3)));
        if (fout0 === 1'b0) dut_reads++;
        if (bv0 === 1'b1) dut_valids++;
        vectors++;
        if (fout0 !== ~rd) begin miscompares++; $display("FAIL fout_n_msb: got %b expected %b", fout0, ~rd); end
        vectors++;
        if (fout1 !== ~rd) begin miscompares++; $display("FAIL fout_n_lsb: got %b expected %b", fout1, ~rd); end
        vectors++;
        if (bv0 !== m_busy || bv1 !== m_busy) begin miscompares++; $display("FAIL byte_valid: got %b/%b expected %b", bv0, bv1, m_busy); end
        vectors++;
        if (busy0 !== m_busy) begin miscompares++; $display("FAIL busy: got %b expected %b", busy0, m_busy); end
        vectors++;
        if (wc0 !== m_cnt || wc1 !== m_cnt) begin miscompares++; $display("FAIL word_cnt: got %0d/%0d expected %0d", wc0, wc1, m_cnt); end
        if (m_busy) begin
            vectors++;
            if (bl0 !== (m_bidx == 3) || bl1 !== (m_bidx == 3)) begin
                miscompares++; $display("FAIL byte_last: got %b/%b expected %b", bl0, bl1, (m_bidx == 3));
            end
            vectors++;
            if (bd0 !== sb_msb[0]) begin miscompares++; $display("FAIL byte_data_msb: got %h expected %h", bd0, sb_msb[0]); end
            vectors++;
            if (bd1 !== sb_lsb[0]) begin miscompares++; $display("FAIL byte_data_lsb: got %h expected %h", bd1, sb_lsb[0]); end
        end
        @(posedge Clk);
        if (!RstN || !ClrN) begin
            m_busy = 1'b0; m_bidx = 0; m_cnt = '0;
            sb_msb.delete(); sb_lsb.delete();
        end else begin
            if (acc) begin
                void'(sb_msb.pop_front());
                void'(sb_lsb.pop_front());
                if (m_bidx != 3) m_bidx++;
                else m_busy = 1'b0;
            end
            if (rd) begin
                w = fifo_q.pop_front();
                for (int i = 0; i < 4; i++) begin
                    sb_msb.push_back(w[31-8*i -: 8]);
                    sb_lsb.push_back(w[8*i +: 8]);
                end
                m_bidx = 0; m_busy = 1'b1; m_cnt = m_cnt + 1'b1;
            end
        end
        @(negedge Clk);
    endtask

    task automatic test_reset();
        RstN = 1'b0; EnN = 1'b1; ClrN = 1'b1; Byte_Ready = 1'b0;
        step(); step();
        RstN = 1'b1; EnN = 1'b0;
        for (int i = 0; i < 10; i++) step();
        vectors++;
        if (bd0 !== 8'h00 || bl0 !== 1'b0) begin miscompares++; $display("FAIL reset_data: got %h/%b expected 00/0", bd0, bl0); end
    endtask

    task automatic test_single();
        dut_reads = 0;
        Byte_Ready = 1'b1;
        fifo_q.push_back(32'hA1B2C3D4);
        for (int i = 0; i < 7; i++) step();
        vectors++;
        if (dut_reads != 1) begin miscompares++; $display("FAIL single_reads: got %0d expected 1", dut_reads); end
        vectors++;
        if (bv0 !== 1'b0 || wc0 !== 3'd1) begin miscompares++; $display("FAIL single_end: got valid %b cnt %0d expected 0 1", bv0, wc0); end
    endtask

    task automatic test_back_to_back();
        dut_reads = 0; dut_valids = 0;
        fifo_q.push_back(32'h01020304);
        fifo_q.push_back(32'h05060708);
        fifo_q.push_back(32'h090A0B0C);
        for (int i = 0; i < 14; i++) step();
        vectors++;
        if (dut_reads != 3) begin miscompares++; $display("FAIL b2b_reads: got %0d expected 3", dut_reads); end
        vectors++;
        if (dut_valids != 12) begin miscompares++; $display("FAIL b2b_valid_cycles: got %0d expected 12", dut_valids); end
        vectors++;
        if (wc0 !== 3'd4) begin miscompares++; $display("FAIL b2b_cnt: got %0d expected 4", wc0); end
    endtask

    task automatic test_backpressure();
        dut_reads = 0;
        fifo_q.push_back(32'h11223344);
        for (int i = 0; i < 24; i++) begin
            Byte_Ready = ((i % 4) == 0) || ((i % 4) == 3);
            step();
        end
        Byte_Ready = 1'b1;
        vectors++;
        if (dut_reads != 1) begin miscompares++; $display("FAIL bp_reads: got %0d expected 1", dut_reads); end
        vectors++;
        if (bv0 !== 1'b0 || wc0 !== 3'd5) begin miscompares++; $display("FAIL bp_end: got valid %b cnt %0d expected 0 5", bv0, wc0); end
    endtask

    task automatic test_enable_clear();
        dut_reads = 0;
        Byte_Ready = 1'b1;
        fifo_q.push_back(32'hCAFEF00D);
        fifo_q.push_back(32'h12345678);
        step(); step(); step();
        EnN = 1'b1;
        for (int i = 0; i < 4; i++) step();
        vectors++;
        if (dut_reads != 1) begin miscompares++; $display("FAIL en_reads: got %0d expected 1", dut_reads); end
        vectors++;
        if (bv0 !== 1'b0 || wc0 !== 3'd6) begin miscompares++; $display("FAIL en_idle: got valid %b cnt %0d expected 0 6", bv0, wc0); end
        EnN = 1'b0;
        step(); step(); step();
        ClrN = 1'b0;
        step();
        ClrN = 1'b1;
        step();
        vectors++;
        if (bv0 !== 1'b0 || wc0 !== 3'd0) begin miscompares++; $display("FAIL clr: got valid %b cnt %0d expected 0 0", bv0, wc0); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 9; i++) fifo_q.push_back(32'h1000_0000 + i * 32'h0101_0101);
        for (int i = 0; i < 39; i++) step();
        vectors++;
        if (wc0 !== 3'd1) begin miscompares++; $display("FAIL wrap_cnt: got %0d expected 1", wc0); end
    endtask

    task automatic test_async_reset();
        fifo_q.push_back(32'h0F1E2D3C);
        fifo_q.push_back(32'h55AA6699);
        step(); step(); step();
        #2 RstN = 1'b0;
        #1;
        vectors++;
        if (fout0 !== 1'b1 || bv0 !== 1'b0 || bl0 !== 1'b0 || busy0 !== 1'b0 || bd0 !== 8'h00 || wc0 !== 3'd0) begin
            miscompares++;
            $display("FAIL async_reset: got fout %b valid %b last %b busy %b data %h cnt %0d expected 1 0 0 0 00 0",
                     fout0, bv0, bl0, busy0, bd0, wc0);
        end
        m_busy = 1'b0; m_bidx = 0; m_cnt = '0;
        sb_msb.delete(); sb_lsb.delete();
        @(negedge Clk);
        step();
        RstN = 1'b1;
        dut_reads = 0;
        for (int i = 0; i < 6; i++) step();
        vectors++;
        if (dut_reads != 1 || wc0 !== 3'd1) begin miscompares++; $display("FAIL post_reset: got reads %0d cnt %0d expected 1 1", dut_reads, wc0); end
    endtask

    initial begin
        RstN = 1'b0; EnN = 1'b1; ClrN = 1'b1; Byte_Ready = 1'b0;
        F_EmptyN = 1'b0; F_Data = '0;
        @(negedge Clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_enable_clear();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_byte_unpacker.md
Name: fifo_byte_unpacker

Overview:
- Downstream consumer of the 32-bit FIFO.
- Drains words through the FIFO's active-low read strobe and show-ahead data port, then emits each word as a sequence of bytes over a valid/ready byte interface.
- Feeds the byte-wide transmit path.
- Re-bursts words back-to-back with no idle cycle while the FIFO stays non-empty.

Parameters:
- FWIDTH, 32, FIFO word width; must be an integer multiple of BWIDTH.
- BWIDTH, 8, output byte width.
- MSB_FIRST, 1, 1 = most-significant byte emitted first; 0 = least-significant first.
- WCWIDTH, 16, width of the drained-word counter.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- RstN  in  1  asynchronous, active-low reset.
- EnN  in  1  active-low enable; high blocks new FIFO reads, but the word in progress still completes.
- ClrN  in  1  synchronous active-low clear/abort.
- F_Data  in  FWIDTH  FIFO head word; show-ahead, valid while F_EmptyN=1.
- F_EmptyN  in  1  FIFO non-empty flag; high = at least one word present.
- FOutN  out  1  active-low FIFO read strobe, one cycle per word consumed.
- Byte_Data  out  BWIDTH  current byte.
- Byte_Valid  out  1  Byte_Data valid.
- Byte_Ready  in  1  downstream accepts the byte when Byte_Valid & Byte_Ready.
- Byte_Last  out  1  high with the final byte of a word.
- Busy  out  1  high while a word is held.
- Word_Cnt  out  WCWIDTH  number of words read from the FIFO.

Behaviour:
- Definitions:
  - NB = FWIDTH/BWIDTH.
  - bidx = byte index counter, width clog2(NB), min 1.
  - hold = FWIDTH capture register.
  - accept = Byte_Valid & Byte_Ready.
- Reset (RstN=0, immediate): state IDLE, hold=0, bidx=0, Word_Cnt=0. Outputs: Byte_Valid=0, Byte_Last=0, Busy=0, Byte_Data=0, FOutN=1.
- State IDLE (Byte_Valid=0):
  - If ClrN=1, EnN=0 and F_EmptyN=1: FOutN=0 this cycle; hold<=F_Data, bidx<=0, Word_Cnt+1, go to SHIFT.
- State SHIFT (Byte_Valid=1, Busy=1):
  - Byte_Data = hold slice selected by bidx. MSB_FIRST=1: bidx 0 -> hold[FWIDTH-1 -: BWIDTH]. MSB_FIRST=0: bidx 0 -> hold[BWIDTH-1:0].
  - Byte_Last = (bidx==NB-1).
  - accept with bidx<NB-1: bidx+1.
  - accept with bidx==NB-1 and reload allowed (ClrN=1, EnN=0, F_EmptyN=1): FOutN=0 in the same cycle, hold<=F_Data, bidx<=0, Word_Cnt+1, stay in SHIFT. This is the no-bubble path.
  - accept with bidx==NB-1 and reload not allowed: go to IDLE.
  - no accept: hold, bidx, Byte_Data and Byte_Last stay stable.
- FOutN:
  - Combinational: FOutN = ~(ClrN & ~EnN & F_EmptyN & (IDLE | (accept & Byte_Last))).
  - Low for exactly one cycle per captured word.
  - Never low while F_EmptyN=0, so no underflow reads.
- Latency:
  - FIFO going non-empty while IDLE: FOutN low the same cycle; first byte valid the next cycle.
  - Full word drains in NB accepted cycles.
  - Sustained throughput: 1 byte/cycle with Byte_Ready held high.
- EnN high mid-word: remaining bytes still emitted; no reload; ends in IDLE.
- ClrN=0 (synchronous):
  - Next edge: state IDLE, Byte_Valid=0, bidx=0, Word_Cnt=0; FOutN=1 while ClrN=0.
  - hold contents are discarded.
  - ClrN dominates a simultaneous accept/reload.
- Word_Cnt wraps modulo 2^WCWIDTH.
- RstN asserted mid-word: partial word is lost; the FIFO is not re-read.

Test Plan:
- Reset, FIFO empty: F_EmptyN=0 for 10 cycles -> FOutN=1, Byte_Valid=0, Word_Cnt=0 throughout.
- Single word: F_Data=0xA1B2C3D4, F_EmptyN=1 for one read, Byte_Ready=1, MSB_FIRST=1.
  - FOutN low 1 cycle.
  - Bytes A1,B2,C3,D4 on 4 consecutive cycles; Byte_Last only with D4.
  - Then IDLE, Word_Cnt=1.
- Back-to-back: 3 words queued, Byte_Ready=1 -> 12 consecutive valid bytes with no gap; FOutN low exactly 3 times, each in the Byte_Last accept cycle (first one from IDLE); Word_Cnt=3.
- Backpressure: Byte_Ready toggled 1,0,0,1,... on word 0x11223344 with MSB_FIRST=0 -> bytes 44,33,22,11 in order; Byte_Data stable while stalled; no extra FOutN pulses.
- Enable/clear: EnN raised after byte 2 of word 1 with word 2 pending -> word 1 completes, no FOutN pulse, IDLE. Then ClrN pulsed low mid-word -> Byte_Valid=0 next cycle, Word_Cnt=0.
- Async reset mid-word: RstN low at bidx=2 -> all outputs at reset values immediately; after release, the next FIFO word is read fresh with bidx=0.
